// File: rtl/matrix_wb_sequencer.sv
// Arbitrates the scalar register-file write port between WB-stage scalar writes
// and serialised 128-bit matrix results; scalar writes always win.
module matrix_wb_sequencer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int WORDS      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_wen,
  input  logic [ADDR_W-1:0]        s_waddr,
  input  logic [DATA_W-1:0]        s_wdata,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [ADDR_W-1:0]        m_rd,
  input  logic [WORDS*DATA_W-1:0]  m_data,
  output logic                     rf_wen,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     busy,
  output logic [ADDR_W-1:0]        busy_rd,
  output logic                     stall_o,
  output logic                     done
);
  localparam int MAT_W = WORDS * DATA_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         starve;
  logic [MAT_W-1:0]   mat;
  logic [DATA_W-1:0]  cur_word;
  logic [ADDR_W-1:0]  cur_addr;
  logic [3:0]         starve_inc;
  logic               last;

  assign m_ready    = (state == IDLE);
  assign cur_word   = mat[cnt*DATA_W +: DATA_W];
  // Address wraps naturally at 2^ADDR_W.
  assign cur_addr   = busy_rd + ADDR_W'(cnt);
  assign last       = (cnt == CNT_W'(WORDS-1));
  assign starve_inc = (starve == 4'hF) ? starve : starve + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      starve   <= '0;
      mat      <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= 1'b0;
      busy_rd  <= '0;
      stall_o  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (s_wen) begin
        rf_wen   <= 1'b1;
        rf_waddr <= s_waddr;
        rf_wdata <= s_wdata;
      end else if (state == DRAIN) begin
        // x0 slot is consumed but never written
        rf_wen   <= (cur_addr != '0);
        rf_waddr <= cur_addr;
        rf_wdata <= cur_word;
      end else begin
        rf_wen   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (m_valid) begin
            mat     <= m_data;
            busy_rd <= m_rd;
            cnt     <= '0;
            starve  <= '0;
            stall_o <= 1'b0;
            busy    <= 1'b1;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (s_wen) begin
            starve  <= starve_inc;
            stall_o <= (starve_inc >= 4'(STARVE_MAX));
          end else begin
            cnt     <= cnt + CNT_W'(1);
            starve  <= '0;
            stall_o <= 1'b0;
            if (last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_wb_sequencer.sv
// Randomised + directed bench for matrix_wb_sequencer; reference model keeps the
// pending matrix words as a queue of (address, data) writes.
module tb_matrix_wb_sequencer;
  localparam int DATA_W = 32, ADDR_W = 5, WORDS = 4, STARVE_MAX = 3;
  localparam int MAT_W = WORDS * DATA_W;

  logic clk = 1'b0, rst_n = 1'b0;
  logic s_wen = 1'b0, m_valid = 1'b0;
  logic [ADDR_W-1:0] s_waddr = '0, m_rd = '0;
  logic [DATA_W-1:0] s_wdata = '0;
  logic [MAT_W-1:0]  m_data = '0;
  logic m_ready, rf_wen, busy, stall_o, done;
  logic [ADDR_W-1:0] rf_waddr, busy_rd;
  logic [DATA_W-1:0] rf_wdata;

  matrix_wb_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS(WORDS), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .s_wen(s_wen), .s_waddr(s_waddr), .s_wdata(s_wdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .busy_rd(busy_rd), .stall_o(stall_o), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  wr_t pend[$];
  int  defer;
  logic e_wen, e_done, e_busy, e_stall;
  logic [ADDR_W-1:0] e_addr, e_busy_rd;
  logic [DATA_W-1:0] e_data;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%h exp=%h", tag, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    defer = 0;
    e_wen = 0; e_done = 0; e_busy = 0; e_stall = 0;
    e_addr = '0; e_busy_rd = '0; e_data = '0;
  endtask

  task automatic chk_outs(input string pfx);
    chk({pfx, "rf_wen"},   32'(rf_wen),   32'(e_wen));
    chk({pfx, "rf_waddr"}, 32'(rf_waddr), 32'(e_addr));
    chk({pfx, "rf_wdata"}, rf_wdata,      e_data);
    chk({pfx, "busy"},     32'(busy),     32'(e_busy));
    chk({pfx, "busy_rd"},  32'(busy_rd),  32'(e_busy_rd));
    chk({pfx, "stall_o"},  32'(stall_o),  32'(e_stall));
    chk({pfx, "done"},     32'(done),     32'(e_done));
  endtask

  // One clock: drive at negedge, predict, check #1 after the rising edge.
  task automatic cyc(input logic sw, input logic [ADDR_W-1:0] sa, input logic [DATA_W-1:0] sd,
                     input logic mv, input logic [ADDR_W-1:0] mr, input logic [MAT_W-1:0] md);
    logic idle;
    wr_t w;
    @(negedge clk);
    s_wen = sw; s_waddr = sa; s_wdata = sd; m_valid = mv; m_rd = mr; m_data = md;
    idle = (pend.size() == 0);
    #1 chk("m_ready", 32'(m_ready), 32'(idle));
    e_done = 0;
    if (sw) begin
      e_wen = 1; e_addr = sa; e_data = sd;
      if (!idle) defer++;
    end else if (!idle) begin
      w = pend.pop_front();
      e_wen = (w.a != 0); e_addr = w.a; e_data = w.d;
      defer = 0;
      e_done = (pend.size() == 0);
    end else begin
      e_wen = 0;
    end
    if (idle && mv) begin
      for (int i = 0; i < WORDS; i++) begin
        w.a = ADDR_W'((int'(mr) + i) % (1 << ADDR_W));
        w.d = md[i*DATA_W +: DATA_W];
        pend.push_back(w);
      end
      e_busy_rd = mr;
      defer = 0;
    end
    e_busy  = (pend.size() != 0);
    e_stall = e_busy && (defer >= STARVE_MAX);
    @(posedge clk);
    #1 chk_outs("");
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    s_wen = 0; m_valid = 0;
    rst_n = 1'b0;
    model_reset();
    #1 chk_outs("rst_");
    chk("rst_m_ready", 32'(m_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [MAT_W-1:0] d1, d2;

  initial begin
    d1 = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    d2 = {32'h44440003, 32'h33330002, 32'h22220001, 32'h11110000};
    do_reset();

    // plain drain into r8..r11
    cyc(1'b0, '0, '0, 1'b1, 5'd8, d1);
    idle_cyc(5);
    // scalar write interleaved on the 2nd drain cycle
    cyc(1'b0, '0, '0, 1'b1, 5'd8, d1);
    cyc(1'b0, '0, '0, 1'b0, '0, '0);
    cyc(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0);
    idle_cyc(5);
    // address wrap through x0
    cyc(1'b0, '0, '0, 1'b1, 5'd30, d2);
    idle_cyc(5);
    // starvation: five deferrals, then release
    cyc(1'b0, '0, '0, 1'b1, 5'd12, d1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 5'(i + 1), 32'(i), 1'b0, '0, '0);
    idle_cyc(6);
    // reset in the middle of a drain
    cyc(1'b0, '0, '0, 1'b1, 5'd16, d2);
    idle_cyc(2);
    #2 do_reset();
    idle_cyc(3);
    // back-to-back results with m_valid held high
    cyc(1'b0, '0, '0, 1'b1, 5'd20, d1);
    for (int i = 0; i < 9; i++) cyc(1'b0, '0, '0, 1'b1, 5'd24, d2);
    idle_cyc(2);
    // acceptance coincident with a scalar write
    cyc(1'b1, 5'd3, 32'hCAFE, 1'b1, 5'd2, d1);
    idle_cyc(5);

    for (int i = 0; i < 600; i++) begin
      logic [MAT_W-1:0] md;
      for (int k = 0; k < WORDS; k++) md[k*DATA_W +: DATA_W] = $urandom;
      cyc(($urandom_range(0, 2) == 0), 5'($urandom), $urandom,
          ($urandom_range(0, 1) == 0), 5'($urandom), md);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matrix_wb_sequencer.md
Name: matrix_wb_sequencer

Overview:
- Shares the single 32-bit scalar register-file write port between two sources:
  - scalar writeback results: the 32-bit regs-write data from the writeback stage;
  - 128-bit matrix results destined for the scalar register file.
- Accepts one matrix result at a time and serialises it into WORDS consecutive 32-bit register writes.
- Scalar writebacks always have priority. Matrix words fill the idle write-port cycles.
- Provides busy/stall outputs to the hazard unit and pipeline control.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- WORDS, 4, words per matrix result. MAT_W = WORDS*DATA_W = 128.
- STARVE_MAX, 3, consecutive deferred matrix cycles before stall_o is raised (range 1..15).

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_wen  in  1  scalar writeback enable from the WB stage.
- s_waddr  in  ADDR_W  scalar destination register.
- s_wdata  in  DATA_W  scalar writeback data.
- m_valid  in  1  matrix result valid.
- m_ready  out  1  sequencer can accept a matrix result.
- m_rd  in  ADDR_W  first destination register of the matrix result.
- m_data  in  MAT_W  matrix result; word i = bits [i*DATA_W +: DATA_W].
- rf_wen  out  1  register-file write enable, registered.
- rf_waddr  out  ADDR_W  register-file write address, registered.
- rf_wdata  out  DATA_W  register-file write data, registered.
- busy  out  1  a matrix result is being drained.
- busy_rd  out  ADDR_W  base register of the result being drained.
- stall_o  out  1  request to freeze the pipeline so matrix words can drain.
- done  out  1  one-cycle pulse, coincident with the last matrix word on rf_*.

Behaviour:
- Async reset (rst_n=0):
  - rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, busy_rd=0, stall_o=0, done=0.
  - State = IDLE; word counter and starve counter cleared.
  - m_ready=1 during reset, since it is combinational from state==IDLE.
  - A reset mid-drain discards the remaining matrix words. No partial write completes after rst_n falls.
- States:
  - IDLE: m_ready=1.
    - On m_valid&&m_ready, latch m_data and m_rd, set cnt=0, and go to DRAIN.
    - busy=1 and busy_rd=m_rd from the next cycle.
  - DRAIN: m_ready=0.
    - Each cycle, if s_wen=0, issue word cnt and increment cnt.
    - If s_wen=1, the scalar write wins and cnt holds.
    - When word WORDS-1 is issued, return to IDLE: busy=0 and m_ready=1 from the next cycle.
- Write-port rule, with one-cycle latency from inputs to rf_*:
  - If s_wen=1 at edge N: rf_wen=1, rf_waddr=s_waddr, rf_wdata=s_wdata, valid in cycle N+1. This applies in any state.
  - Else if DRAIN: rf_waddr=(busy_rd+cnt) mod 2^ADDR_W (wraps 31->0). rf_wdata = latched word cnt.
    - rf_wen=1, except rf_wen=0 when the computed address is 0 (x0 is never written).
    - cnt still advances when the x0 write is suppressed.
  - Else: rf_wen=0. rf_waddr/rf_wdata hold their previous values.
  - s_wen with s_waddr=0 is passed through unchanged; the register file ignores x0.
- done:
  - Asserted in the same cycle as the rf_* outputs for word WORDS-1, including when that write is suppressed for x0.
  - Cleared the following cycle.
- Starvation:
  - The starve counter increments on each DRAIN cycle where s_wen=1, and clears on any DRAIN cycle that issues a word.
  - When starve==STARVE_MAX, stall_o=1 (registered) until the next matrix word issues.
  - Upstream guarantees s_wen=0 while stall_o=1. If s_wen=1 anyway, the scalar write still wins and stall_o stays high.
  - stall_o=0 in IDLE.
- Back-to-back: a new matrix result is accepted on the first IDLE cycle after the last word issues, giving a minimum of WORDS+1 cycles per result. Acceptance in the same cycle as an s_wen write is legal.
- The hazard unit uses busy/busy_rd to block reads and writes of rd..rd+WORDS-1. This block does not check register overlap.

Test Plan:
- Reset, then m_valid=1, m_rd=8, m_data={32'hDDDD0003,32'hCCCC0002,32'hBBBB0001,32'hAAAA0000}, s_wen=0 -> rf writes r8=AAAA0000, r9=BBBB0001, r10=CCCC0002, r11=DDDD0003 on 4 consecutive cycles; done with the r11 write; m_ready=1 the cycle after.
- Same load, with s_wen=1 (s_waddr=5, s_wdata=0x1234) on the 2nd drain cycle -> sequence is r8, r5=0x1234, r9, r10, r11; done delayed one cycle.
- m_rd=30 -> writes r30 and r31, x0 suppressed (rf_wen=0, cnt advances), then r1; done on the r1 cycle.
- s_wen=1 for 5 consecutive drain cycles, STARVE_MAX=3 -> stall_o rises after 3 deferrals; drop s_wen -> a word issues and stall_o falls the next cycle.
- Pull rst_n low after 2 words are issued -> outputs go to reset values asynchronously; no further matrix writes; m_ready=1 after release.
- Assert m_valid continuously with two results -> the second is accepted on the cycle after the first done; 10 total cycles for 8 writes.
